// File: rtl/sdrc_req_split.sv
// Request splitter: queues application requests, scales them to the SDRAM width
// and issues page- and MAX_CHUNK-bounded chunks with decoded bank/row/column.
module sdrc_req_split #(
  parameter int APP_AW    = 26,
  parameter int APP_RW    = 9,
  parameter int ID_W      = 4,
  parameter int BA_W      = 2,
  parameter int RA_W      = 13,
  parameter int Q_DEPTH   = 4,
  parameter int MAX_CHUNK = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        cfg_colbits,
  input  logic              cfg_map_mode,
  input  logic [1:0]        sdr_width,
  input  logic              req,
  input  logic [ID_W-1:0]   req_id,
  input  logic [APP_AW-1:0] req_addr,
  input  logic [APP_RW-1:0] req_len,
  input  logic              req_wrap,
  input  logic              req_wr_n,
  output logic              req_ack,
  output logic              r2x_idle,
  output logic              r2b_req,
  output logic [ID_W-1:0]   r2b_req_id,
  output logic              r2b_start,
  output logic              r2b_last,
  output logic              r2b_wrap,
  output logic              r2b_write,
  output logic [BA_W-1:0]   r2b_ba,
  output logic [RA_W-1:0]   r2b_raddr,
  output logic [12:0]       r2b_caddr,
  output logic [APP_RW+1:0] r2b_len,
  input  logic              b2r_ack
);

  localparam int AW = APP_AW + 2;
  localparam int LW = APP_RW + 2;
  localparam int PW = $clog2(Q_DEPTH);
  localparam int TW = (LW > 13) ? LW : 13;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [AW-1:0]   addr;
    logic [LW-1:0]   len;
    logic            wrap;
    logic            wr_n;
  } entry_t;

  typedef struct packed {
    logic            req;
    logic [ID_W-1:0] id;
    logic            start;
    logic            last;
    logic            wrap;
    logic            write;
    logic [BA_W-1:0] ba;
    logic [RA_W-1:0] raddr;
    logic [12:0]     caddr;
    logic [LW-1:0]   len;
  } chunk_t;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  entry_t        r_mem [Q_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_full, w_empty, w_push, w_pop;
  entry_t        w_in, w_head;

  state_t        r_state, w_next_state;
  chunk_t        r_chunk;
  logic [AW-1:0] r_cur_addr, w_next_addr, w_src_addr, w_shift_a;
  logic [LW-1:0] r_rem_len, w_next_rem, w_src_rem, w_chunk_len;
  logic          w_load, w_adv, w_src_wrap;
  logic [3:0]    w_col_bits;
  logic [TW-1:0] w_col, w_page_rem, w_len_t;
  logic [BA_W-1:0] w_ba;
  logic [RA_W-1:0] w_ra;

  assign w_full  = (r_count == (PW+1)'(Q_DEPTH));
  assign w_empty = (r_count == '0);
  assign req_ack = req & ~w_full & reset_n;
  assign w_push  = req_ack;
  assign w_head  = r_mem[r_rd_ptr];

  // Address and length are stored already scaled to SDRAM beats.
  always_comb begin
    w_in.id   = req_id;
    w_in.wrap = req_wrap;
    w_in.wr_n = req_wr_n;
    case (sdr_width)
      2'b00:   begin w_in.addr = {2'b00, req_addr};       w_in.len = {2'b00, req_len};       end
      2'b01:   begin w_in.addr = {1'b0, req_addr, 1'b0};  w_in.len = {1'b0, req_len, 1'b0};  end
      default: begin w_in.addr = {req_addr, 2'b00};       w_in.len = {req_len, 2'b00};       end
    endcase
  end

  // NOTE: queue storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  assign w_next_addr = r_cur_addr + AW'(r_chunk.len);
  assign w_next_rem  = r_rem_len - r_chunk.len;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_adv        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head.len != '0) begin
            w_load       = 1'b1;
            w_next_state = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (b2r_ack) begin
          if (w_next_rem != '0) begin
            w_adv = 1'b1;
          end else if (!w_empty && w_head.len != '0) begin
            w_pop  = 1'b1;
            w_load = 1'b1;
          end else begin
            // Zero-length heads are left for IDLE to discard.
            w_next_state = S_IDLE;
          end
        end
      end
    endcase
  end

  // Next chunk is cut from either a fresh queue head or the continuing request.
  always_comb begin
    w_src_addr = w_load ? w_head.addr : w_next_addr;
    w_src_rem  = w_load ? w_head.len  : w_next_rem;
    w_src_wrap = w_load ? w_head.wrap : r_chunk.wrap;
    w_col_bits = 4'd8 + {2'b00, cfg_colbits};
    w_col      = TW'(w_src_addr & ~({AW{1'b1}} << w_col_bits));
    w_page_rem = (TW'(1) << w_col_bits) - w_col;
    w_len_t    = TW'(w_src_rem);
    if (!w_src_wrap) begin
      if (w_page_rem < w_len_t)       w_len_t = w_page_rem;
      if (TW'(MAX_CHUNK) < w_len_t)   w_len_t = TW'(MAX_CHUNK);
    end
    w_chunk_len = LW'(w_len_t);
    w_shift_a   = w_src_addr >> w_col_bits;
    if (cfg_map_mode) begin
      w_ra = RA_W'(w_shift_a);
      w_ba = BA_W'(w_shift_a >> RA_W);
    end else begin
      w_ba = BA_W'(w_shift_a);
      w_ra = RA_W'(w_shift_a >> BA_W);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_chunk    <= '0;
      r_cur_addr <= '0;
      r_rem_len  <= '0;
    end else if (w_load || w_adv) begin
      r_chunk.req   <= 1'b1;
      r_chunk.start <= w_load;
      if (w_load) begin
        r_chunk.id    <= w_head.id;
        r_chunk.wrap  <= w_head.wrap;
        r_chunk.write <= ~w_head.wr_n;
      end
      r_chunk.ba    <= w_ba;
      r_chunk.raddr <= w_ra;
      r_chunk.caddr <= 13'(w_col);
      r_chunk.len   <= w_chunk_len;
      r_chunk.last  <= (w_chunk_len == w_src_rem);
      r_cur_addr    <= w_src_addr;
      r_rem_len     <= w_src_rem;
    end else if (w_next_state == S_IDLE) begin
      r_chunk.req <= 1'b0;
    end
  end

  assign r2b_req    = r_chunk.req;
  assign r2b_req_id = r_chunk.id;
  assign r2b_start  = r_chunk.start;
  assign r2b_last   = r_chunk.last;
  assign r2b_wrap   = r_chunk.wrap;
  assign r2b_write  = r_chunk.write;
  assign r2b_ba     = r_chunk.ba;
  assign r2b_raddr  = r_chunk.raddr;
  assign r2b_caddr  = r_chunk.caddr;
  assign r2b_len    = r_chunk.len;
  assign r2x_idle   = (r_state == S_IDLE) & w_empty & ~req;

endmodule

// File: tb/tb_sdrc_req_split.sv
// Bench for sdrc_req_split: directed scenarios plus random batches, checked
// against an arithmetic chunking model of each accepted request.
module tb_sdrc_req_split;

  localparam int APP_AW = 26, APP_RW = 9, ID_W = 4, BA_W = 2, RA_W = 13;
  localparam int Q_DEPTH = 4, MAX_CHUNK = 64;
  localparam longint ASPACE = longint'(1) << (APP_AW + 2);
  localparam longint NB = longint'(1) << BA_W;
  localparam longint NR = longint'(1) << RA_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        cfg_colbits;
  logic              cfg_map_mode;
  logic [1:0]        sdr_width;
  logic              req;
  logic [ID_W-1:0]   req_id;
  logic [APP_AW-1:0] req_addr;
  logic [APP_RW-1:0] req_len;
  logic              req_wrap;
  logic              req_wr_n;
  logic              req_ack;
  logic              r2x_idle;
  logic              r2b_req;
  logic [ID_W-1:0]   r2b_req_id;
  logic              r2b_start;
  logic              r2b_last;
  logic              r2b_wrap;
  logic              r2b_write;
  logic [BA_W-1:0]   r2b_ba;
  logic [RA_W-1:0]   r2b_raddr;
  logic [12:0]       r2b_caddr;
  logic [APP_RW+1:0] r2b_len;
  logic              b2r_ack;

  sdrc_req_split #(
    .APP_AW(APP_AW), .APP_RW(APP_RW), .ID_W(ID_W), .BA_W(BA_W), .RA_W(RA_W),
    .Q_DEPTH(Q_DEPTH), .MAX_CHUNK(MAX_CHUNK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_colbits(cfg_colbits), .cfg_map_mode(cfg_map_mode),
    .sdr_width(sdr_width), .req(req), .req_id(req_id), .req_addr(req_addr),
    .req_len(req_len), .req_wrap(req_wrap), .req_wr_n(req_wr_n), .req_ack(req_ack),
    .r2x_idle(r2x_idle), .r2b_req(r2b_req), .r2b_req_id(r2b_req_id), .r2b_start(r2b_start),
    .r2b_last(r2b_last), .r2b_wrap(r2b_wrap), .r2b_write(r2b_write), .r2b_ba(r2b_ba),
    .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr), .r2b_len(r2b_len), .b2r_ack(b2r_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     id;
    bit     start, last, wrap, write;
    longint ba, ra, col, len;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_chunk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Reference: cut the scaled request at page ends and MAX_CHUNK, decode with division.
  task automatic model_req(input int id, input longint app_addr, input int app_len,
                           input bit wrap, input bit wr_n);
    longint a, l, page, pr, n, mul;
    bit     first;
    exp_t   e;
    mul   = (sdr_width == 2'b00) ? 1 : (sdr_width == 2'b01) ? 2 : 4;
    a     = (app_addr * mul) % ASPACE;
    l     = longint'(app_len) * mul;
    page  = longint'(1) << (8 + int'(cfg_colbits));
    first = 1'b1;
    while (l > 0) begin
      n = l;
      if (!wrap) begin
        pr = page - (a % page);
        if (pr < n) n = pr;
        if (MAX_CHUNK < n) n = MAX_CHUNK;
      end
      e.id = id; e.start = first; e.last = (n == l); e.wrap = wrap; e.write = !wr_n;
      e.len = n; e.col = a % page;
      if (!cfg_map_mode) begin
        e.ba = (a / page) % NB;
        e.ra = (a / (page * NB)) % NR;
      end else begin
        e.ra = (a / page) % NR;
        e.ba = (a / (page * NR)) % NB;
      end
      exp_q.push_back(e);
      a = (a + n) % ASPACE;
      l = l - n;
      first = 1'b0;
    end
  endtask

  task automatic cmp_chunk(input exp_t e);
    string s;
    s = $sformatf("chunk%0d", n_chunk);
    check({s, "_id"},    64'(r2b_req_id), 64'(e.id));
    check({s, "_start"}, 64'(r2b_start),  64'(e.start));
    check({s, "_last"},  64'(r2b_last),   64'(e.last));
    check({s, "_wrap"},  64'(r2b_wrap),   64'(e.wrap));
    check({s, "_write"}, 64'(r2b_write),  64'(e.write));
    check({s, "_ba"},    64'(r2b_ba),     64'(e.ba));
    check({s, "_row"},   64'(r2b_raddr),  64'(e.ra));
    check({s, "_col"},   64'(r2b_caddr),  64'(e.col));
    check({s, "_len"},   64'(r2b_len),    64'(e.len));
    n_chunk++;
  endtask

  // Called at a negedge; returns at the negedge after the accepting clock edge.
  task automatic send(input int id, input longint addr, input int len, input bit wrap,
                      input bit wr_n, input bit keep);
    bit got;
    req = 1'b1; req_id = ID_W'(id); req_addr = APP_AW'(addr);
    req_len = APP_RW'(len); req_wrap = wrap; req_wr_n = wr_n;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ack) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check($sformatf("ack_req%0d", id), 64'(got), 64'd1);
    if (got) model_req(id, addr, len, wrap, wr_n);
    @(negedge clk);
    if (!keep) req = 1'b0;
  endtask

  task automatic drain(input bit rand_ack, input bit contig);
    int budget, extra;
    bit seen, ack;
    budget = 0; seen = 1'b0;
    while (exp_q.size() > 0 && budget < 5000) begin
      @(negedge clk);
      if (contig && seen) check("req_back_to_back", 64'(r2b_req), 64'd1);
      ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r2b_req && ack) begin
        cmp_chunk(exp_q.pop_front());
        seen = 1'b1;
      end
      b2r_ack = ack;
      budget++;
    end
    check("drain_complete", 64'(exp_q.size()), 64'd0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b2r_ack = 1'b1;
      if (r2b_req) extra++;
    end
    @(negedge clk);
    b2r_ack = 1'b0;
    check("no_extra_chunks", 64'(extra), 64'd0);
    check("idle_after_drain", 64'(r2x_idle), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int extra, nreq;
    reset_n = 1'b0; req = 1'b0; b2r_ack = 1'b0;
    cfg_colbits = 2'b00; cfg_map_mode = 1'b0; sdr_width = 2'b00;
    req_id = '0; req_addr = '0; req_len = '0; req_wrap = 1'b0; req_wr_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_r2b_req", 64'(r2b_req), 64'd0);
    check("reset_r2b_len", 64'(r2b_len), 64'd0);
    req = 1'b1; #1;
    check("reset_no_ack", 64'(req_ack), 64'd0);
    req = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    check("reset_idle", 64'(r2x_idle), 64'd1);

    // Page crossing split, with first-chunk latency.
    send(1, 26'h0F0, 9'h40, 1'b0, 1'b0, 1'b0);
    check("latency_t1", 64'(r2b_req), 64'd0);
    @(negedge clk);
    check("latency_t2", 64'(r2b_req), 64'd1);
    drain(1'b0, 1'b0);

    // MAX_CHUNK splitting with continuous acceptance.
    cfg_colbits = 2'b01;
    send(2, 26'h0, 200, 1'b0, 1'b1, 1'b0);
    drain(1'b0, 1'b1);

    // 16-bit scaling.
    cfg_colbits = 2'b00; sdr_width = 2'b01;
    send(3, 26'h7C, 9'h10, 1'b0, 1'b0, 1'b0);
    drain(1'b1, 1'b0);

    // Wrap request is never split.
    sdr_width = 2'b00;
    send(4, 26'h0FC, 9'h10, 1'b1, 1'b1, 1'b0);
    drain(1'b0, 1'b0);

    // Queue full: five accepted, sixth held until the first chunk is taken.
    for (int i = 0; i < 5; i++) send(i + 1, longint'(i) * 16, 4, 1'b0, 1'b0, 1'b1);
    req_id = 4'd6; req_addr = 26'h100; req_len = 9'd4; req_wrap = 1'b0; req_wr_n = 1'b1;
    #1;
    check("full_hold_a", 64'(req_ack), 64'd0);
    @(negedge clk); #1;
    check("full_hold_b", 64'(req_ack), 64'd0);
    check("full_issue", 64'(r2b_req), 64'd1);
    cmp_chunk(exp_q.pop_front());
    b2r_ack = 1'b1;
    @(negedge clk);
    b2r_ack = 1'b0; #1;
    check("full_release", 64'(req_ack), 64'd1);
    model_req(6, 26'h100, 4, 1'b0, 1'b1);
    @(negedge clk);
    req = 1'b0;
    drain(1'b1, 1'b0);

    // Reset in the middle of a split with two requests queued.
    send(7, 26'h0, 256, 1'b0, 1'b0, 1'b0);
    send(8, 26'h200, 8, 1'b0, 1'b0, 1'b0);
    send(9, 26'h300, 8, 1'b0, 1'b0, 1'b0);
    check("mid_issue", 64'(r2b_req), 64'd1);
    cmp_chunk(exp_q.pop_front());
    b2r_ack = 1'b1;
    @(negedge clk);
    b2r_ack = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_reset_req", 64'(r2b_req), 64'd0);
    check("mid_reset_idle", 64'(r2x_idle), 64'd1);
    req = 1'b1; #1;
    check("mid_reset_no_ack", 64'(req_ack), 64'd0);
    req = 1'b0; reset_n = 1'b1;
    exp_q.delete();
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b2r_ack = 1'b1;
      if (r2b_req) extra++;
    end
    @(negedge clk);
    b2r_ack = 1'b0;
    check("no_chunks_after_reset", 64'(extra), 64'd0);

    // Bank-first mapping, 8-bit width, 10 column bits.
    cfg_map_mode = 1'b1; cfg_colbits = 2'b10; sdr_width = 2'b10;
    send(10, 26'h0C0_0100, 3, 1'b0, 1'b0, 1'b0);
    drain(1'b0, 1'b0);

    // Random batches under random configurations and accept patterns.
    for (int b = 0; b < 8; b++) begin
      cfg_colbits  = 2'($urandom_range(0, 3));
      cfg_map_mode = 1'($urandom_range(0, 1));
      sdr_width    = 2'($urandom_range(0, 3));
      nreq = $urandom_range(1, 5);
      for (int r = 0; r < nreq; r++) begin
        send($urandom_range(0, 15), longint'($urandom_range(0, 32'h03FF_FFFF)),
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 511),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
      end
      drain(1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
